// File: rtl/y86_pkg.sv
// y86_pkg: icode constants and default PC width shared across the Y86 pipeline stages
package y86_pkg;
    localparam int PC_W_DEF = 64;
    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;
endpackage

// File: rtl/ras_stack.sv
// ras_stack: circular return-address stack; a push when full overwrites the oldest entry
module ras_stack #(
    parameter int PC_W = 64,
    parameter int RAS_DEPTH = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            push,
    input  logic            pop,
    input  logic            flush,
    input  logic [PC_W-1:0] push_data,
    output logic [PC_W-1:0] top,
    output logic            empty
);
    localparam int AW = $clog2(RAS_DEPTH);
    localparam int CW = AW + 1;
    logic [PC_W-1:0] mem [RAS_DEPTH];
    logic [AW-1:0]   ptr;
    logic [CW-1:0]   count;
    assign empty = count == '0;
    assign top   = mem[ptr - AW'(1)];
    // flush only clears the count so the pointer keeps its position
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr   <= '0;
            count <= '0;
        end else if (flush) begin
            count <= '0;
        end else if (push) begin
            ptr   <= ptr + AW'(1);
            count <= (count == CW'(RAS_DEPTH)) ? count : count + CW'(1);
        end else if (pop && !empty) begin
            ptr   <= ptr - AW'(1);
            count <= count - CW'(1);
        end
    end
    always_ff @(posedge clk) begin
        if (push && !flush) mem[ptr] <= push_data;
    end
endmodule

// File: rtl/fetch_pc_predict.sv
// fetch_pc_predict: next-PC prediction and F pipeline register; define RAS_EN to add a return-address stack for ret
module fetch_pc_predict
    import y86_pkg::*;
#(
    parameter int PC_W = PC_W_DEF,
    parameter int RAS_DEPTH = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [3:0]      f_icode,
    input  logic [PC_W-1:0] f_valC,
    input  logic [PC_W-1:0] f_valP,
    input  logic            f_valid,
    input  logic            F_stall,
    input  logic            ras_flush,
    output logic [PC_W-1:0] f_predPC,
    output logic [PC_W-1:0] F_predPC,
    output logic            ras_hit
);
    logic            use_ras;
    logic [PC_W-1:0] ras_top;
`ifdef RAS_EN
    logic ras_empty;
    assign use_ras = f_valid && f_icode == IRET && !ras_empty;
    ras_stack #(.PC_W(PC_W), .RAS_DEPTH(RAS_DEPTH)) u_ras (
        .clk      (clk),
        .reset    (reset),
        .push     (!F_stall && f_valid && f_icode == ICALL),
        .pop      (!F_stall && use_ras),
        .flush    (ras_flush),
        .push_data(f_valP),
        .top      (ras_top),
        .empty    (ras_empty)
    );
`else
    logic unused_flush;
    assign unused_flush = ras_flush;
    assign use_ras = 1'b0;
    assign ras_top = '0;
`endif
    // always-taken policy: jumps and calls both go to valC
    always_comb begin
        f_predPC = !f_valid ? f_valP :
                   (f_icode == IJXX || f_icode == ICALL) ? f_valC :
                   use_ras ? ras_top : f_valP;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            F_predPC <= '0;
            ras_hit  <= 1'b0;
        end else if (!F_stall) begin
            F_predPC <= f_predPC;
            ras_hit  <= use_ras;
        end
    end
endmodule

// File: doc/fetch_pc_predict.md
Name: fetch_pc_predict

Overview:
- Fetch-stage PC predictor and F pipeline register for the Y86 pipeline.
- Computes the predicted next PC from the instruction currently in fetch.
- Registers that prediction into F_predPC, which the fetch PC-select logic consumes next cycle.
- Optional return-address stack (RAS) predicts ret targets so fetch need not wait for W_valM.

Parameters:
- PC_W, 64, PC/address width.
- RAS_DEPTH, 8, RAS entries (power of two, ≥2); used only with RAS feature.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- f_icode  in  4  icode of instruction in fetch
- f_valC  in  PC_W  constant/destination field of fetched instruction
- f_valP  in  PC_W  address of next sequential instruction
- f_valid  in  1  fetch holds a real instruction (0 = bubble/imem error)
- F_stall  in  1  hold F register (load/use or ret hazard)
- ras_flush  in  1  mispredicted branch resolved; discard RAS contents
- f_predPC  out  PC_W  combinational prediction
- F_predPC  out  PC_W  registered prediction
- ras_hit  out  1  registered: F_predPC came from RAS (0 when RAS compiled out)

Behaviour:
- Reset (async, active-high): F_predPC=0, ras_hit=0, RAS empty (count=0, ptr=0). Reset mid-operation discards all RAS state immediately.
- Prediction (combinational) for f_predPC:
  - f_valid=0: f_valP.
  - icode 7 (jXX) or 8 (call): f_valC. Always-taken policy.
  - icode 9 (ret): RAS top if RAS_EN and non-empty; else f_valP.
  - Other icodes: f_valP.
- F register update:
  - Rising clk, F_stall=0: F_predPC<=f_predPC; ras_hit<=(RAS used this cycle).
  - F_stall=1: F_predPC and ras_hit hold; no RAS push/pop.
  - Latency: one cycle from f_* inputs to F_predPC.
- RAS (RAS_EN only). Circular buffer with ptr and count (0..RAS_DEPTH). Updates only when F_stall=0 and f_valid=1:
  - call: write f_valP at ptr; ptr<=ptr+1 mod RAS_DEPTH; count<=min(count+1, RAS_DEPTH).
  - Push when full overwrites the oldest entry (wrap).
  - ret, count>0: ptr<=ptr-1 mod RAS_DEPTH; count<=count-1; top = entry[ptr-1].
  - ret, count=0: no pop; predict f_valP; ras_hit=0.
- ras_flush (synchronous): count<=0; ptr unchanged. Takes priority over a same-cycle push or pop. Prediction that cycle is still computed from pre-flush state.
- ras_flush with F_stall=1: flush still applies.
- No arithmetic beyond mod-RAS_DEPTH pointer wrap. Widths fixed at PC_W; no truncation.

Optional Feature:
- Macro RAS_EN.
- Defined: RAS storage, push/pop, ret prediction, ras_hit as above.
- Undefined: no RAS logic. ret predicts f_valP. ras_hit tied 0. ras_flush ignored.

Decomposition:
- Shared package y86_pkg: icode constants (IHALT=0, INOP=1, IRRMOVQ=2, IIRMOVQ=3, IRMMOVQ=4, IMRMOVQ=5, IOPQ=6, IJXX=7, ICALL=8, IRET=9, IPUSHQ=A, IPOPQ=B) and PC_W default. Shared with decode/execute and PC-select.
- One sub-module: ras_stack (params PC_W, RAS_DEPTH). Ports: push, pop, flush, push_data, top, empty. Instantiated only under RAS_EN.

Test Plan:
- Reset asserted async mid-cycle → F_predPC=0 and ras_hit=0 immediately, before the next clk edge.
- f_icode=7, f_valC=0x100, f_valP=0x0A, F_stall=0 → after 1 clk F_predPC=0x100. Same inputs with f_icode=6 → F_predPC=0x0A.
- F_stall=1 while inputs change to icode 8 / valC 0x200 → F_predPC holds its previous value; RAS count unchanged.
- RAS_EN: call (valP=0x40) then ret → F_predPC=0x40, ras_hit=1. A second ret (stack empty, valP=0x50) → F_predPC=0x50, ras_hit=0.
- RAS_EN, RAS_DEPTH=8: 9 calls with valP=0x10..0x90, then 9 rets → first 8 predict 0x90 down to 0x20; 9th predicts its own valP with ras_hit=0.
- RAS_EN: call (valP=0x40), then ras_flush with a simultaneous call (valP=0x60), then ret → ret predicts its own valP, ras_hit=0 (flush wins over the push).
